// File: rtl/press_sequencer.sv
// Button front end: 2-flop sync, per-bit debounce, rising-edge capture into
// pending flags, round-robin grant, and a position sequencer with idle timeout.
module press_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ROUNDS          = 10,
  parameter int TIMEOUT         = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       press_valid,
  output logic [1:0] press_id,
  output logic [3:0] state,
  output logic       round_done,
  output logic       timeout,
  output logic [3:0] pending
);

  localparam logic [3:0]  FIRST_POS = 4'd1;
  localparam logic [3:0]  LAST_POS  = 4'(ROUNDS);
  localparam logic [3:0]  END_POS   = 4'(ROUNDS + 1);
  localparam logic [7:0]  DB_LIM    = 8'(DEBOUNCE_CYCLES);
  localparam logic [19:0] TO_LAST   = 20'(TIMEOUT - 1);
  localparam logic        TO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {PH_FIRST, PH_MID, PH_END} phase_t;

  logic [3:0]      sync1_r, sync2_r, db_lvl_r, db_prev_r;
  logic [3:0][7:0] db_cnt_r;
  logic [3:0]      pend_r, pend_s;
  logic [1:0]      ptr_r, ptr_s;
  logic [3:0]      pos_r, pos_s;
  logic [19:0]     idle_r, idle_s;
  logic            pv_r, rd_r, to_r, rd_s, to_s;
  logic [1:0]      id_r;
  logic            grant_s, expire_s;
  logic [1:0]      gid_s, idx_s;
  logic [3:0]      rise_s;
  phase_t          phase_s;

  // Synchronizer and per-bit debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= 4'd0;
      sync2_r   <= 4'd0;
      db_lvl_r  <= 4'd0;
      db_prev_r <= 4'd0;
      db_cnt_r  <= '0;
    end else begin
      sync1_r   <= btn;
      sync2_r   <= sync1_r;
      db_prev_r <= db_lvl_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] != db_lvl_r[i]) begin
          if (db_cnt_r[i] + 8'd1 == DB_LIM) begin
            db_lvl_r[i] <= ~db_lvl_r[i];
            db_cnt_r[i] <= 8'd0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + 8'd1;
          end
        end else begin
          db_cnt_r[i] <= 8'd0;
        end
      end
    end
  end

  // Arbitration, position sequencing and idle timeout (next-state logic).
  always_comb begin
    grant_s  = 1'b0;
    gid_s    = 2'd0;
    idx_s    = 2'd0;
    rd_s     = 1'b0;
    to_s     = 1'b0;
    pos_s    = pos_r;
    ptr_s    = ptr_r;
    idle_s   = 20'd0;
    rise_s   = db_lvl_r & ~db_prev_r;
    // Descending scan so the closest bit at or after the pointer is the last written.
    for (int k = 3; k >= 0; k--) begin
      idx_s = ptr_r + 2'(k);
      if (pend_r[idx_s]) begin
        grant_s = 1'b1;
        gid_s   = idx_s;
      end else begin
        grant_s = grant_s;
      end
    end
    if (pos_r == END_POS) begin
      phase_s = PH_END;
    end else if (pos_r == FIRST_POS) begin
      phase_s = PH_FIRST;
    end else begin
      phase_s = PH_MID;
    end
    expire_s = TO_EN && (phase_s == PH_MID) && (idle_r == TO_LAST) && !grant_s;
    pend_s   = pend_r | rise_s;
    if (grant_s) begin
      pend_s = (pend_r & ~(4'd1 << gid_s)) | rise_s;
      ptr_s  = gid_s + 2'd1;
      case (phase_s)
        PH_END:  pos_s = FIRST_POS;
        PH_FIRST,
        PH_MID: begin
          pos_s = pos_r + 4'd1;
          rd_s  = (pos_r == LAST_POS);
        end
        default: pos_s = FIRST_POS;
      endcase
    end else if (expire_s) begin
      pend_s = 4'd0;
      pos_s  = FIRST_POS;
      to_s   = 1'b1;
    end else if (TO_EN && phase_s == PH_MID) begin
      idle_s = idle_r + 20'd1;
    end else begin
      idle_s = 20'd0;
    end
  end

  // Sequencer state and registered output pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 4'd0;
      ptr_r  <= 2'd0;
      pos_r  <= FIRST_POS;
      idle_r <= 20'd0;
      pv_r   <= 1'b0;
      id_r   <= 2'd0;
      rd_r   <= 1'b0;
      to_r   <= 1'b0;
    end else begin
      pend_r <= pend_s;
      ptr_r  <= ptr_s;
      pos_r  <= pos_s;
      idle_r <= idle_s;
      pv_r   <= grant_s;
      id_r   <= grant_s ? gid_s : 2'd0;
      rd_r   <= rd_s;
      to_r   <= to_s;
    end
  end

  assign press_valid = pv_r;
  assign press_id    = id_r;
  assign state       = pos_r;
  assign round_done  = rd_r;
  assign timeout     = to_r;
  assign pending     = pend_r;

endmodule

// File: doc/press_sequencer.md
Name: press_sequencer

Overview:
- Front-end controller for the 4-button press-counting path.
- Synchronizes and debounces four raw buttons, and turns each debounced press into one pending request.
- Grants at most one press per cycle using round-robin arbitration.
- Sequences a position counter through ROUNDS positions plus an end position, with an inactivity timeout that restarts the sequence; the position drives the display/scoring logic downstream.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples needed to change a debounced level (range 1..255).
- ROUNDS, 10: positions before the end position (range 1..14).
- TIMEOUT, 1000: idle cycles in positions 2..ROUNDS before restart; 0 disables (range 0..2^20-1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn  in  4  raw asynchronous buttons, active-high, one bit per button.
- press_valid  out  1  one-cycle pulse: a press was accepted this cycle.
- press_id  out  2  index of the accepted button; valid only with press_valid, else 0.
- state  out  4  position: 1..ROUNDS while running, ROUNDS+1 = end.
- round_done  out  1  one-cycle pulse on the transition into the end position.
- timeout  out  1  one-cycle pulse when the inactivity timer expires.
- pending  out  4  pending-request bits, for debug/status.

Behaviour:
- Reset values, applied at a clk edge with rst=1:
  - state=1; press_valid, press_id, round_done, timeout all 0.
  - pending=0; synchronizer and debounced levels 0; debounce and timeout counters 0; round-robin pointer 0.
  - Reset overrides all other activity in the same cycle.
- Synchronizer: two flops per bit.
- Debounce, per bit:
  - The counter increments while the synchronized sample differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Edge detect:
  - A 0->1 debounced transition sets that bit's pending flag.
  - Release (1->0) generates nothing.
  - A new rising edge on a bit already pending is absorbed (no queueing beyond one per button).
- Arbitration:
  - Each cycle with pending!=0, grant the first set bit searching from the pointer upward, mod 4.
  - On grant: clear that pending bit, set pointer to grantee+1 mod 4, and register press_valid=1 and press_id=grantee for one cycle.
  - A pending bit set in the same cycle as a grant is not eligible until the next cycle.
- Latency: a single isolated press, first sampled high at edge E and held stable, produces press_valid high after edge E+DEBOUNCE_CYCLES+3.
- State machine (state register is the position):
  - RUN (1..ROUNDS), grant:
    - If state<ROUNDS: state <= state+1.
    - If state==ROUNDS: state <= ROUNDS+1 and round_done=1 in the same cycle as press_valid.
  - END (ROUNDS+1), grant: state <= 1 (wrap) with press_valid. No round_done, no timeout in END.
  - Any state with no grant: hold.
- Timeout:
  - A 20-bit idle counter clears on every grant and whenever state==1 or state==ROUNDS+1; otherwise it increments.
  - When it equals TIMEOUT-1 in RUN with no grant that cycle: state <= 1, timeout=1, pending cleared, counter cleared.
  - If a grant and expiry coincide, the grant wins and there is no timeout.
  - TIMEOUT=0: the counter is held at 0 and never fires.
- Simultaneous presses:
  - Buttons debounced high in the same cycle are granted on consecutive cycles in round-robin order.
  - Each grant advances state; one may wrap END->1.
- Reset mid-operation: all state is lost. A button held through reset produces exactly one press after DEBOUNCE_CYCLES+3 cycles once reset deasserts.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES synchronized samples produces no press.

Test Plan:
- Reset, then btn=0001 held 20 cycles (DEBOUNCE_CYCLES=4) -> exactly one press_valid, press_id=0, 7 cycles after first sample; state 1->2.
- Ten separate presses of btn[2] -> state steps 2..10, then 11 with round_done on the 10th press_valid; an 11th press -> state=1, no round_done.
- btn=1010 asserted in the same cycle, pointer=0 -> press_valid on two consecutive cycles, press_id=1 then 3, state +2, pointer ends at 0.
- 3-cycle raw glitch on btn[0] -> no press_valid; pending stays 0.
- TIMEOUT=50, one press to state=2, then idle -> timeout pulse after 50 idle cycles, state=1; idle in END for 200 cycles -> no timeout.
- rst=1 for one cycle at state=6 while btn[1] pending -> next cycle state=1, pending=0, press_valid=0; btn[1] held through reset -> one press after 7 cycles.
